ctrl_pkt_splitter: RTL and testbench

- Ingress block between the MAC-side AXI Stream and the packet filter / parser / packet-FIFO front end.
- Classifies each packet from its first two 256-bit beats.
- Control packets (IPv4/UDP to the configured control port) go to a control AXIS port that feeds the stage table-configuration path.
- Every other packet is forwarded unchanged on the data AXIS port.
- One-beat holding register per packet; full throughput once the destination is known.

---
 rtl/rmt_axis_pkg.sv | 15 +
 rtl/hdr_classify.sv | 27 ++
 rtl/ctrl_pkt_splitter.sv | 154 +++++++++++++++
 tb/tb_ctrl_pkt_splitter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmt_axis_pkg.sv
// rtl/rmt_axis_pkg.sv - shared header constants and state/destination types for the ingress splitter
package rmt_axis_pkg;

   localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;

   // Byte offsets within a 256-bit beat; beat1 offset is relative to the second beat
   localparam int ETHTYPE_OFF      = 12;
   localparam int IPPROTO_OFF      = 23;
   localparam int UDP_DPORT_OFF_B1 = 4;

   typedef enum logic [1:0] {IDLE, HDR, BODY, TAIL} state_t;
   typedef enum logic {DATA, CTRL} dest_t;

endpackage

// File: rtl/hdr_classify.sv
// rtl/hdr_classify.sv - combinational control-packet detector over the first two beats
module hdr_classify
   import rmt_axis_pkg::*;
#(
   parameter int          DATA_W        = 256,
   parameter logic [15:0] CTRL_UDP_PORT = 16'hF1F2
) (
   input  logic [DATA_W-1:0] beat0_i,
   input  logic [DATA_W-1:0] beat1_i,
   output logic              is_ctrl_o
);

   logic ipv4_hit;
   logic udp_hit;
   logic port_hit;
   logic unused_bits;

   assign ipv4_hit = (beat0_i[8*ETHTYPE_OFF +: 8]       == ETH_TYPE_IPV4[15:8]) &&
                     (beat0_i[8*(ETHTYPE_OFF+1) +: 8]   == ETH_TYPE_IPV4[7:0]);
   assign udp_hit  = (beat0_i[8*IPPROTO_OFF +: 8]       == IP_PROTO_UDP);
   assign port_hit = (beat1_i[8*UDP_DPORT_OFF_B1 +: 8]     == CTRL_UDP_PORT[15:8]) &&
                     (beat1_i[8*(UDP_DPORT_OFF_B1+1) +: 8] == CTRL_UDP_PORT[7:0]);

   assign is_ctrl_o   = ipv4_hit & udp_hit & port_hit;
   assign unused_bits = ^{beat0_i, beat1_i};

endmodule

// File: rtl/ctrl_pkt_splitter.sv
// rtl/ctrl_pkt_splitter.sv - steers control UDP packets to c_m_axis, everything else to m_axis
module ctrl_pkt_splitter
   import rmt_axis_pkg::*;
#(
   parameter int          C_S_AXIS_DATA_WIDTH  = 256,
   parameter int          C_S_AXIS_TUSER_WIDTH = 128,
   parameter logic [15:0] CTRL_UDP_PORT        = 16'hF1F2,
   parameter int          CNT_WIDTH            = 32
) (
   input  logic                              clk,
   input  logic                              aresetn,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic                              s_axis_tlast,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic                              m_axis_tlast,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
   output logic                              c_m_axis_tvalid,
   input  logic                              c_m_axis_tready,
   output logic                              c_m_axis_tlast,
   output logic [CNT_WIDTH-1:0]              data_pkt_cnt,
   output logic [CNT_WIDTH-1:0]              ctrl_pkt_cnt
);

   localparam int KEEP_W = C_S_AXIS_DATA_WIDTH/8;

   state_t                            state_q;
   dest_t                             dest_q;
   logic [C_S_AXIS_DATA_WIDTH-1:0]    h_data_q;
   logic [KEEP_W-1:0]                 h_keep_q;
   logic [C_S_AXIS_TUSER_WIDTH-1:0]   h_user_q;
   logic                              h_last_q;
   logic                              h_valid_q;
   logic [CNT_WIDTH-1:0]              data_cnt_q;
   logic [CNT_WIDTH-1:0]              ctrl_cnt_q;

   logic   is_ctrl;
   dest_t  hdr_dest_d;
   dest_t  dest_sel;
   logic   sel_tready;
   logic   out_valid;
   logic   in_ready;
   logic   in_fire;
   logic   out_fire;

   hdr_classify #(
      .DATA_W        (C_S_AXIS_DATA_WIDTH),
      .CTRL_UDP_PORT (CTRL_UDP_PORT)
   ) u_classify (
      .beat0_i   (h_data_q),
      .beat1_i   (s_axis_tdata),
      .is_ctrl_o (is_ctrl)
   );

   assign hdr_dest_d = is_ctrl ? CTRL : DATA;
   // In HDR the destination is resolved live from the incoming beat1
   assign dest_sel   = (state_q == HDR) ? hdr_dest_d : dest_q;
   assign sel_tready = (dest_sel == CTRL) ? c_m_axis_tready : m_axis_tready;

   always_comb begin
      out_valid = 1'b0;
      in_ready  = 1'b0;
      case (state_q)
         IDLE: in_ready = 1'b1;
         HDR: begin
            out_valid = s_axis_tvalid;
            in_ready  = s_axis_tvalid & sel_tready;
         end
         BODY: begin
            out_valid = h_valid_q;
            in_ready  = ~h_valid_q | sel_tready;
         end
         TAIL: out_valid = 1'b1;
         default: ;
      endcase
   end

   assign s_axis_tready = in_ready & aresetn;
   assign in_fire       = s_axis_tvalid & s_axis_tready;
   assign out_fire      = out_valid & sel_tready;

   assign m_axis_tvalid   = out_valid & (dest_sel == DATA);
   assign c_m_axis_tvalid = out_valid & (dest_sel == CTRL);
   assign m_axis_tdata    = h_data_q;
   assign m_axis_tkeep    = h_keep_q;
   assign m_axis_tuser    = h_user_q;
   assign m_axis_tlast    = h_last_q;
   assign c_m_axis_tdata  = h_data_q;
   assign c_m_axis_tkeep  = h_keep_q;
   assign c_m_axis_tuser  = h_user_q;
   assign c_m_axis_tlast  = h_last_q;
   assign data_pkt_cnt    = data_cnt_q;
   assign ctrl_pkt_cnt    = ctrl_cnt_q;

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state_q    <= IDLE;
         dest_q     <= DATA;
         h_data_q   <= '0;
         h_keep_q   <= '0;
         h_user_q   <= '0;
         h_last_q   <= 1'b0;
         h_valid_q  <= 1'b0;
         data_cnt_q <= '0;
         ctrl_cnt_q <= '0;
      end else begin
         if (in_fire) begin
            h_data_q  <= s_axis_tdata;
            h_keep_q  <= s_axis_tkeep;
            h_user_q  <= s_axis_tuser;
            h_last_q  <= s_axis_tlast;
            h_valid_q <= 1'b1;
         end
         case (state_q)
            IDLE: if (in_fire) begin
               if (s_axis_tlast) begin
                  dest_q  <= DATA;
                  state_q <= TAIL;
               end else begin
                  state_q <= HDR;
               end
            end
            HDR: if (in_fire) begin
               dest_q  <= hdr_dest_d;
               state_q <= s_axis_tlast ? TAIL : BODY;
            end
            BODY: begin
               if (in_fire) begin
                  if (s_axis_tlast) state_q <= TAIL;
               end else if (out_fire) begin
                  h_valid_q <= 1'b0;
               end
            end
            TAIL: if (out_fire) begin
               h_valid_q <= 1'b0;
               if (dest_q == CTRL) ctrl_cnt_q <= ctrl_cnt_q + CNT_WIDTH'(1);
               else                data_cnt_q <= data_cnt_q + CNT_WIDTH'(1);
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_pkt_splitter.sv
// tb/tb_ctrl_pkt_splitter.sv - directed self-checking bench for ctrl_pkt_splitter
module tb_ctrl_pkt_splitter;

   logic         clk = 1'b0;
   logic         aresetn = 1'b0;
   logic [255:0] s_tdata = '0;
   logic [31:0]  s_tkeep = '0;
   logic [127:0] s_tuser = '0;
   logic         s_tvalid = 1'b0;
   logic         s_tlast = 1'b0;
   logic         s_tready;
   logic [255:0] m_tdata, c_tdata;
   logic [31:0]  m_tkeep, c_tkeep;
   logic [127:0] m_tuser, c_tuser;
   logic         m_tvalid, m_tlast, c_tvalid, c_tlast;
   logic         m_rdy = 1'b1;
   logic         c_rdy = 1'b1;
   logic         toggle_en = 1'b0;
   logic         tog_bit = 1'b1;
   logic [3:0]   tog_pat = 4'b1001;
   int           tog_i = 0;
   logic         c_tready;
   logic [31:0]  data_cnt, ctrl_cnt;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   logic [255:0] tx_d[$];
   logic [160:0] tx_s[$];
   logic [255:0] m_d[$], c_d[$];
   logic [160:0] m_s[$], c_s[$];
   int           m_cyc[$], c_cyc[$], in_cyc[$];
   logic         m_seen = 1'b0;
   logic         c_seen = 1'b0;

   assign c_tready = toggle_en ? tog_bit : c_rdy;

   ctrl_pkt_splitter dut (
      .clk             (clk),
      .aresetn         (aresetn),
      .s_axis_tdata    (s_tdata),
      .s_axis_tkeep    (s_tkeep),
      .s_axis_tuser    (s_tuser),
      .s_axis_tvalid   (s_tvalid),
      .s_axis_tready   (s_tready),
      .s_axis_tlast    (s_tlast),
      .m_axis_tdata    (m_tdata),
      .m_axis_tkeep    (m_tkeep),
      .m_axis_tuser    (m_tuser),
      .m_axis_tvalid   (m_tvalid),
      .m_axis_tready   (m_rdy),
      .m_axis_tlast    (m_tlast),
      .c_m_axis_tdata  (c_tdata),
      .c_m_axis_tkeep  (c_tkeep),
      .c_m_axis_tuser  (c_tuser),
      .c_m_axis_tvalid (c_tvalid),
      .c_m_axis_tready (c_tready),
      .c_m_axis_tlast  (c_tlast),
      .data_pkt_cnt    (data_cnt),
      .ctrl_pkt_cnt    (ctrl_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (toggle_en) begin
         tog_bit = tog_pat[tog_i % 4];
         tog_i++;
      end
   end

   always @(negedge clk) begin
      #2;
      if (m_tvalid) m_seen = 1'b1;
      if (c_tvalid) c_seen = 1'b1;
      if (m_tvalid && m_rdy) begin
         m_d.push_back(m_tdata);
         m_s.push_back({m_tuser, m_tkeep, m_tlast});
         m_cyc.push_back(cyc);
      end
      if (c_tvalid && c_tready) begin
         c_d.push_back(c_tdata);
         c_s.push_back({c_tuser, c_tkeep, c_tlast});
         c_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      tx_d.delete(); tx_s.delete();
      m_d.delete(); m_s.delete(); m_cyc.delete();
      c_d.delete(); c_s.delete(); c_cyc.delete();
      in_cyc.delete();
      m_seen = 1'b0;
      c_seen = 1'b0;
   endtask

   task automatic build(input logic [15:0] etype, input logic [7:0] proto,
                        input logic [15:0] dport, input int nb, input int id);
      logic [255:0] d;
      for (int i = 0; i < nb; i++) begin
         for (int j = 0; j < 8; j++)
            d[32*j +: 32] = 32'hA500_0000 ^ (id << 16) ^ (i << 8) ^ j;
         if (i == 0) begin
            d[96 +: 8]  = etype[15:8];
            d[104 +: 8] = etype[7:0];
            d[184 +: 8] = proto;
         end
         if (i == 1) begin
            d[32 +: 8] = dport[15:8];
            d[40 +: 8] = dport[7:0];
         end
         tx_d.push_back(d);
         tx_s.push_back({{4{32'h5A5A_0000 ^ (id << 8) ^ i}},
                         (i == nb - 1) ? 32'h00FF_FFFF : 32'hFFFF_FFFF,
                         (i == nb - 1)});
      end
   endtask

   task automatic send_pkt(input int first, input int n);
      int guard;
      for (int k = first; k < first + n; k++) begin
         @(negedge clk);
         s_tdata  = tx_d[k];
         {s_tuser, s_tkeep, s_tlast} = tx_s[k];
         s_tvalid = 1'b1;
         guard = 0;
         forever begin
            #1;
            if (s_tready) begin
               in_cyc.push_back(cyc);
               break;
            end
            guard++;
            if (guard > 200) begin
               check("s_accept_timeout", 0, 1);
               break;
            end
            @(negedge clk);
         end
      end
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic wait_cnt(input int dexp, input int cexp, input string tag);
      for (int g = 0; g < 200; g++) begin
         if (data_cnt == dexp && ctrl_cnt == cexp) break;
         @(negedge clk);
      end
      #3;
      check({tag, "_data_cnt"}, data_cnt, dexp);
      check({tag, "_ctrl_cnt"}, ctrl_cnt, cexp);
   endtask

   task automatic check_port(input bit is_c, input int first, input int n, input string tag);
      int got_n;
      got_n = is_c ? c_d.size() : m_d.size();
      check({tag, "_beats"}, got_n, n);
      for (int i = 0; i < n && i < got_n; i++) begin
         check($sformatf("%s_data%0d", tag, i), is_c ? c_d[i] : m_d[i], tx_d[first + i]);
         check($sformatf("%s_side%0d", tag, i), is_c ? c_s[i] : m_s[i], tx_s[first + i]);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      check("rst_s_tready", s_tready, 0);
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_c_tvalid", c_tvalid, 0);
      check("rst_cnts", {data_cnt, ctrl_cnt}, 0);
      @(negedge clk);
      aresetn = 1'b1;
      #1;
      check("idle_s_tready", s_tready, 1);

      // 3-beat UDP data packet
      clear_mon();
      build(16'h0800, 8'h11, 16'h1234, 3, 1);
      send_pkt(0, 3);
      wait_cnt(1, 0, "t1");
      check_port(0, 0, 3, "t1_m");
      check("t1_c_seen", c_seen, 0);
      if (m_cyc.size() > 0 && in_cyc.size() > 1)
         check("t1_beat0_latency", m_cyc[0], in_cyc[1]);
      else
         check("t1_latency_samples", 0, 1);

      // 4-beat control packet
      clear_mon();
      build(16'h0800, 8'h11, 16'hF1F2, 4, 2);
      send_pkt(0, 4);
      wait_cnt(1, 1, "t2");
      check_port(1, 0, 4, "t2_c");
      check("t2_m_seen", m_seen, 0);

      // single-beat packet
      clear_mon();
      build(16'h0800, 8'h11, 16'h0000, 1, 3);
      @(negedge clk);
      s_tdata  = tx_d[0];
      {s_tuser, s_tkeep, s_tlast} = tx_s[0];
      s_tvalid = 1'b1;
      #1;
      if (s_tready) in_cyc.push_back(cyc);
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      #1;
      check("t3_tail_s_tready", s_tready, 0);
      wait_cnt(2, 1, "t3");
      check_port(0, 0, 1, "t3_m");
      if (m_cyc.size() > 0 && in_cyc.size() > 0)
         check("t3_latency", m_cyc[0], in_cyc[0] + 1);
      else
         check("t3_latency_samples", 0, 1);

      // ARP frame with control port bytes still goes to data
      clear_mon();
      build(16'h0806, 8'h11, 16'hF1F2, 2, 4);
      send_pkt(0, 2);
      wait_cnt(3, 1, "t4");
      check_port(0, 0, 2, "t4_m");
      check("t4_c_seen", c_seen, 0);

      // control packet under toggling backpressure, then data packet with data port stalled
      clear_mon();
      build(16'h0800, 8'h11, 16'hF1F2, 5, 5);
      build(16'h0800, 8'h11, 16'h0050, 3, 6);
      m_rdy = 1'b0;
      tog_i = 0;
      toggle_en = 1'b1;
      fork
         begin
            send_pkt(0, 5);
            send_pkt(5, 3);
         end
         begin
            for (int g = 0; g < 400; g++) begin
               if (ctrl_cnt == 2) break;
               @(negedge clk);
            end
            check("t5_ctrl_done", ctrl_cnt, 2);
            @(negedge clk);
            toggle_en = 1'b0;
            m_rdy = 1'b1;
         end
      join
      wait_cnt(4, 2, "t5");
      check_port(1, 0, 5, "t5_c");
      check_port(0, 5, 3, "t5_m");
      if (m_cyc.size() > 0 && c_cyc.size() > 0)
         check("t5_order", m_cyc[0] > c_cyc[c_cyc.size() - 1], 1);
      else
         check("t5_order_samples", 0, 1);

      // reset in the body of a 5-beat packet
      clear_mon();
      build(16'h0800, 8'h11, 16'h1234, 5, 7);
      send_pkt(0, 3);
      @(negedge clk);
      aresetn = 1'b0;
      #1;
      check("t6_rst_s_tready", s_tready, 0);
      @(negedge clk);
      aresetn = 1'b1;
      #1;
      check("t6_m_tvalid", m_tvalid, 0);
      check("t6_c_tvalid", c_tvalid, 0);
      check("t6_cnts", {data_cnt, ctrl_cnt}, 0);
      check("t6_idle_s_tready", s_tready, 1);
      clear_mon();
      build(16'h0800, 8'h11, 16'hF1F2, 2, 8);
      send_pkt(0, 2);
      wait_cnt(0, 1, "t6");
      check_port(1, 0, 2, "t6_c");
      check("t6_m_seen", m_seen, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
